// File: rtl/fir_tap_sequencer.sv
// Write/read sequencer for the 256 x 36 polyphase FIR sample RAM.
// Writes samples circularly; every DECIM-th sample reads back TAPS taps newest-first.
module fir_tap_sequencer #(
  parameter int TAPS  = 64,
  parameter int DECIM = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] x_real,
  input  logic [17:0] x_imag,
  input  logic        x_strobe,
  output logic [35:0] ram_data,
  output logic [7:0]  ram_wraddress,
  output logic        ram_wren,
  output logic [7:0]  ram_rdaddress,
  input  logic [35:0] ram_q,
  output logic [17:0] tap_real,
  output logic [17:0] tap_imag,
  output logic [7:0]  tap_index,
  output logic        tap_valid,
  output logic        tap_first,
  output logic        tap_last,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    READ
  } state_t;

  localparam logic [7:0] PH_LAST = 8'(DECIM - 1);
  localparam logic [7:0] K_LAST  = 8'(TAPS - 1);

  state_t      state_q, state_d;
  logic [7:0]  wp_q, wp_d;
  logic [7:0]  ph_q, ph_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  k_q, k_d;
  logic        wren_q, wren_d;
  logic [7:0]  wraddr_q, wraddr_d;
  logic [35:0] wdata_q, wdata_d;
  logic        tvalid_q, tvalid_d;
  logic [7:0]  tindex_q, tindex_d;
  logic        ovr_q, ovr_d;
  logic        trig;

  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    ph_d     = ph_q;
    base_d   = base_q;
    k_d      = k_q;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    wdata_d  = wdata_q;
    ovr_d    = ovr_q;
    trig     = x_strobe && (ph_q == PH_LAST);

    if (x_strobe) begin
      wren_d   = 1'b1;
      wraddr_d = wp_q;
      wdata_d  = {x_real, x_imag};
      wp_d     = wp_q + 8'd1;
      ph_d     = trig ? 8'd0 : ph_q + 8'd1;
    end

    tvalid_d = (state_q == READ);
    tindex_d = k_q;

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          base_d  = wp_q;
          state_d = ARM;
        end
      end
      ARM: begin
        state_d = READ;
        k_d     = 8'd0;
      end
      READ: begin
        if (k_q == K_LAST) begin
          state_d = IDLE;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // triggers are not queued: anything outside IDLE is lost
    if (trig && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wp_q     <= 8'd0;
      ph_q     <= 8'd0;
      base_q   <= 8'd0;
      k_q      <= 8'd0;
      wren_q   <= 1'b0;
      wraddr_q <= 8'd0;
      wdata_q  <= 36'd0;
      tvalid_q <= 1'b0;
      tindex_q <= 8'd0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      ph_q     <= ph_d;
      base_q   <= base_d;
      k_q      <= k_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wdata_q  <= wdata_d;
      tvalid_q <= tvalid_d;
      tindex_q <= tindex_d;
      ovr_q    <= ovr_d;
    end
  end

  assign ram_data      = wdata_q;
  assign ram_wraddress = wraddr_q;
  assign ram_wren      = wren_q;
  assign ram_rdaddress = base_q - k_q;
  assign tap_real      = ram_q[35:18];
  assign tap_imag      = ram_q[17:0];
  assign tap_index     = tindex_q;
  assign tap_valid     = tvalid_q;
  assign tap_first     = tvalid_q && (tindex_q == 8'd0);
  assign tap_last      = tvalid_q && (tindex_q == K_LAST);
  assign busy          = (state_q != IDLE) || tvalid_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer with a 1-cycle-latency RAM model.
// Expected writes, read addresses and taps are queued by stimulus and popped by a monitor.
module tb_fir_tap_sequencer;

  localparam int TAPS  = 4;
  localparam int DECIM = 2;

  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [35:0] d;
  } ent_t;

  bit          clock = 1'b0;
  logic        reset;
  logic [17:0] x_real, x_imag;
  logic        x_strobe;
  logic [35:0] ram_data;
  logic [7:0]  ram_wraddress;
  logic        ram_wren;
  logic [7:0]  ram_rdaddress;
  logic [35:0] ram_q;
  logic [17:0] tap_real, tap_imag;
  logic [7:0]  tap_index;
  logic        tap_valid, tap_first, tap_last;
  logic        busy, overrun;

  fir_tap_sequencer #(.TAPS(TAPS), .DECIM(DECIM)) dut (
    .clock(clock), .reset(reset),
    .x_real(x_real), .x_imag(x_imag), .x_strobe(x_strobe),
    .ram_data(ram_data), .ram_wraddress(ram_wraddress),
    .ram_wren(ram_wren), .ram_rdaddress(ram_rdaddress),
    .ram_q(ram_q),
    .tap_real(tap_real), .tap_imag(tap_imag), .tap_index(tap_index),
    .tap_valid(tap_valid), .tap_first(tap_first), .tap_last(tap_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM: unwritten words read back a fixed per-address pattern
  function automatic logic [35:0] init_val(int i);
    return {18'(i) ^ 18'h2A5A5, 18'(255 - i)};
  endfunction

  logic [35:0] ram [256];
  bit   [255:0] written;
  always @(posedge clock) begin
    if (ram_wren) begin
      ram[ram_wraddress]     <= ram_data;
      written[ram_wraddress] <= 1'b1;
    end
    ram_q <= written[ram_rdaddress] ? ram[ram_rdaddress]
                                    : init_val(int'(ram_rdaddress));
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model state
  logic [35:0] mmem [256];
  logic [7:0]  m_wp;
  int          m_ph;
  int          next_ok, acc_t, prev_t, ovr_cyc;
  bit          chk_en;
  ent_t        wq[$], rq[$], tq[$];

  function automatic bit in_win(int t);
    return (cyc >= t + 1) && (cyc <= t + TAPS + 2);
  endfunction

  always @(negedge clock) begin
    ent_t e;
    if (chk_en) begin
      if (ram_wren) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", 64'(ram_wren), 64'd0);
        end else begin
          e = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
          chk("wr_addr", 64'(ram_wraddress), 64'(e.a));
          chk("wr_data", 64'(ram_data), 64'(e.d));
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        chk("wr_missing", 64'(ram_wren), 64'd1);
        void'(wq.pop_front());
      end

      if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        e = rq.pop_front();
        chk("rd_addr", 64'(ram_rdaddress), 64'(e.a));
      end

      if (tap_valid) begin
        if (tq.size() == 0) begin
          chk("tap_unexpected", 64'(tap_valid), 64'd0);
        end else begin
          e = tq.pop_front();
          chk("tap_cycle", 64'(cyc), 64'(e.cyc));
          chk("tap_index", 64'(tap_index), 64'(e.a));
          chk("tap_data", 64'({tap_real, tap_imag}), 64'(e.d));
          chk("tap_first", 64'(tap_first), 64'(e.a == 8'd0));
          chk("tap_last", 64'(tap_last), 64'(e.a == 8'(TAPS - 1)));
        end
      end else begin
        chk("tap_first_idle", 64'(tap_first | tap_last), 64'd0);
        if (tq.size() > 0 && tq[0].cyc <= cyc) begin
          chk("tap_missing", 64'(tap_valid), 64'd1);
          void'(tq.pop_front());
        end
      end

      chk("busy", 64'(busy), 64'(in_win(acc_t) || in_win(prev_t)));
      chk("overrun", 64'(overrun), 64'(ovr_cyc >= 0 && cyc >= ovr_cyc));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    wq.delete();
    rq.delete();
    tq.delete();
    m_wp    = 8'd0;
    m_ph    = 0;
    next_ok = 0;
    acc_t   = -1000;
    prev_t  = -1000;
    ovr_cyc = -1;
  endtask

  task automatic do_reset(int n);
    reset  = 1'b1;
    chk_en = 1'b0;
    model_clear();
    repeat (n) tick();
    reset = 1'b0;
    chk("rst_tap_valid", 64'(tap_valid), 64'd0);
    chk("rst_tap_first", 64'(tap_first), 64'd0);
    chk("rst_tap_last", 64'(tap_last), 64'd0);
    chk("rst_tap_index", 64'(tap_index), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_wren", 64'(ram_wren), 64'd0);
    chk("rst_wraddr", 64'(ram_wraddress), 64'd0);
    chk("rst_wdata", 64'(ram_data), 64'd0);
    chk("rst_rdaddr", 64'(ram_rdaddress), 64'd0);
    chk_en = 1'b1;
  endtask

  // issue one strobe in the current cycle and record its consequences
  task automatic strobe(logic [17:0] re, logic [17:0] im);
    int         t;
    logic [7:0] base, a;
    ent_t       e;
    t        = cyc;
    x_strobe = 1'b1;
    x_real   = re;
    x_imag   = im;
    mmem[m_wp] = {re, im};
    e.cyc = t + 1; e.a = m_wp; e.d = {re, im};
    wq.push_back(e);
    if (m_ph == DECIM - 1) begin
      m_ph = 0;
      if (t >= next_ok) begin
        base = m_wp;
        for (int k = 0; k < TAPS; k++) begin
          a = base - 8'(k);
          e.cyc = t + 2 + k; e.a = a; e.d = 36'd0;
          rq.push_back(e);
          e.cyc = t + 3 + k; e.a = 8'(k); e.d = mmem[a];
          tq.push_back(e);
        end
        prev_t  = acc_t;
        acc_t   = t;
        next_ok = t + TAPS + 2;
      end else if (ovr_cyc < 0) begin
        ovr_cyc = t + 1;
      end
    end else begin
      m_ph++;
    end
    m_wp = m_wp + 8'd1;
    tick();
    x_strobe = 1'b0;
  endtask

  task automatic rstrobe();
    strobe(18'($urandom), 18'($urandom));
  endtask

  initial begin
    reset    = 1'b1;
    x_strobe = 1'b0;
    x_real   = '0;
    x_imag   = '0;
    chk_en   = 1'b0;
    for (int i = 0; i < 256; i++) mmem[i] = init_val(i);

    // reset state
    do_reset(3);

    // two strobes 3 cycles apart: base 1, reads 1,0,255,254
    strobe(18'h00011, 18'h00012);
    repeat (2) tick();
    strobe(18'h00022, 18'h00023);
    repeat (12) tick();

    // wrap-around over 258 samples
    do_reset(2);
    for (int n = 0; n < 258; n++) begin
      strobe(18'(n), 18'(n + 1));
      repeat (5) tick();
    end
    repeat (6) tick();

    // back-to-back strobes: dropped triggers, sticky overrun
    do_reset(2);
    repeat (8) rstrobe();
    repeat (12) tick();
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // reset in the middle of a burst (k == 2)
    do_reset(2);
    rstrobe();
    rstrobe();
    repeat (3) tick();
    do_reset(1);
    rstrobe();
    rstrobe();
    repeat (12) tick();

    // writes continue during bursts
    do_reset(2);
    repeat (12) begin
      rstrobe();
      repeat (2) tick();
    end
    repeat (12) tick();

    // random strobe spacing
    do_reset(2);
    repeat (200) begin
      rstrobe();
      repeat ($urandom_range(0, 4)) tick();
    end
    repeat (12) tick();

    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("tq_drained", 64'(tq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
